contador_regresivo: RTL and testbench

CONTADOR_REGRESIVO -- requirements
Module: contador_regresivo

---
 rtl/contador_regresivo.sv | 102 ++++++++++
 tb/tb_contador_regresivo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/contador_regresivo.sv
// Down-counter with start/pause/abort control, optional auto-reload and a
// one-cycle done pulse on each terminal event.
module contador_regresivo #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic         auto_reload,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Next-state logic; priority is abort > start > pause > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      if (load_val != '0) begin
        state_d = RUN;
        count_d = load_val;
      end else begin
        state_d = IDLE;
        count_d = '0;
        done_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (count_q > N'(1)) begin
              count_d = count_q - N'(1);
            end else begin
              // Terminal count: reload if enabled and the reload value is usable.
              done_d = 1'b1;
              if (auto_reload && (load_val != '0)) begin
                count_d = load_val;
              end else begin
                state_d = IDLE;
                count_d = '0;
              end
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_contador_regresivo.sv
// Scoreboard bench for contador_regresivo: directed vectors push expected
// outputs, a monitor pops and compares one entry after each rising edge.
module tb_contador_regresivo;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic         auto_reload = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] count;
  logic         busy, done, zero;

  typedef struct packed {
    logic [N-1:0] c;
    logic         b;
    logic         d;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   vec_idx = 0;

  contador_regresivo #(.N(N)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .abort(abort), .auto_reload(auto_reload), .load_val(load_val),
    .count(count), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int v, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec=%0d actual=%0d required=%0d", name, v, act, req);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input logic t, input logic s, input logic p, input logic a,
                     input logic ar, input logic [N-1:0] lv,
                     input logic [N-1:0] ec, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    tick = t; start = s; pause = p; abort = a; auto_reload = ar; load_val = lv;
    e.c = ec; e.b = eb; e.d = ed;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    int   v;
    v = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count", v, 32'(count), 32'(e.c));
        chk("busy",  v, 32'(busy),  32'(e.b));
        chk("done",  v, 32'(done),  32'(e.d));
        chk("zero",  v, 32'(zero),  32'(e.c == '0));
        v++;
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_count", -1, 32'(count), 32'd0);
    chk("rst_busy",  -1, 32'(busy),  32'd0);
    chk("rst_done",  -1, 32'(done),  32'd0);
    chk("rst_zero",  -1, 32'(zero),  32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Load 3, tick every cycle: 3,2,1,0 with done on reaching 0
    cyc(1, 1, 0, 0, 0, 8'd3, 8'd3, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd3, 8'd2, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd3, 8'd1, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd3, 8'd0, 0, 1);
    cyc(1, 0, 0, 0, 0, 8'd3, 8'd0, 0, 0);
    cyc(0, 0, 1, 0, 0, 8'd3, 8'd0, 0, 0);

    // Auto-reload 5: 5,4,3,2,1,5,... done on every 1->5, zero never high
    cyc(1, 1, 0, 0, 1, 8'd5, 8'd5, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd4, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd3, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd2, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd1, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd5, 1, 1);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd4, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd3, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd2, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd1, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd5, 8'd5, 1, 1);
    cyc(0, 0, 0, 1, 1, 8'd5, 8'd0, 0, 0);

    // Pause at count 2 for 3 cycles; ticks while paused are discarded
    cyc(1, 1, 0, 0, 0, 8'd4, 8'd4, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd4, 8'd3, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd4, 8'd2, 1, 0);
    cyc(1, 0, 1, 0, 0, 8'd4, 8'd2, 1, 0);
    cyc(1, 0, 1, 0, 0, 8'd4, 8'd2, 1, 0);
    cyc(1, 0, 1, 0, 0, 8'd4, 8'd2, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd4, 8'd2, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd4, 8'd1, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd4, 8'd0, 0, 1);

    // Start and abort together during RUN: abort wins, no done
    cyc(0, 1, 0, 0, 0, 8'd6, 8'd6, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd6, 8'd5, 1, 0);
    cyc(1, 1, 0, 1, 0, 8'd9, 8'd0, 0, 0);
    cyc(1, 0, 0, 0, 0, 8'd9, 8'd0, 0, 0);

    // Start with load_val 0: single done pulse, busy stays low
    cyc(0, 1, 0, 0, 0, 8'd0, 8'd0, 0, 1);
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);

    // Restart while running, and restart while paused
    cyc(0, 1, 0, 0, 0, 8'd7, 8'd7, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd7, 8'd6, 1, 0);
    cyc(1, 1, 0, 0, 0, 8'd3, 8'd3, 1, 0);
    cyc(1, 0, 1, 0, 0, 8'd3, 8'd3, 1, 0);
    cyc(1, 1, 1, 0, 0, 8'd200, 8'd200, 1, 0);
    cyc(1, 0, 0, 0, 0, 8'd3, 8'd199, 1, 0);
    cyc(0, 0, 0, 1, 0, 8'd3, 8'd0, 0, 0);

    // load_val sampled only at reload; reload with 0 ends in IDLE with done
    cyc(0, 1, 0, 0, 1, 8'd2, 8'd2, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd9, 8'd1, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd9, 8'd9, 1, 1);
    cyc(0, 0, 0, 1, 1, 8'd9, 8'd0, 0, 0);
    cyc(0, 1, 0, 0, 1, 8'd1, 8'd1, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'd0, 8'd0, 0, 1);
    cyc(1, 0, 0, 0, 1, 8'd0, 8'd0, 0, 0);

    // Async reset between edges with count 7
    cyc(0, 1, 0, 0, 0, 8'd7, 8'd7, 1, 0);
    @(negedge clk);
    tick = 1'b0; start = 1'b0; auto_reload = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_count", -2, 32'(count), 32'd0);
    chk("async_busy",  -2, 32'(busy),  32'd0);
    chk("async_zero",  -2, 32'(zero),  32'd1);
    #1;
    reset = 1'b0;
    cyc(1, 0, 0, 0, 0, 8'd7, 8'd0, 0, 0);
    cyc(1, 0, 0, 0, 0, 8'd7, 8'd0, 0, 0);
    cyc(1, 0, 1, 0, 0, 8'd7, 8'd0, 0, 0);

    // Drain scoreboard with a bounded wait
    vec_idx = 0;
    while (sb.size() > 0 && vec_idx < 20) begin
      @(negedge clk);
      vec_idx++;
    end
    chk("sb_drained", -3, 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
